// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with a one-entry valid/ready holding register.
// Bytes are sampled at the middle of each bit period, counted from the
// synchronised falling edge of the start bit. Framing errors and overruns
// are reported as single-cycle pulses.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 104,
  parameter int CNT_W        = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SERIAL_RX,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  output logic       BUSY
);

  // Refuse to elaborate with a bit period the counter cannot hold or that
  // leaves no room for a mid-bit sample.
  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535 ||
      (longint'(1) << CNT_W) <= longint'(CLKS_PER_BIT)) begin : g_bad_param
    $error("uart_rx_core: illegal CLKS_PER_BIT/CNT_W combination");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // Half a bit period lands the start-bit sample mid-bit; a full period
  // steps from one bit centre to the next.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             sync1_q, sync2_q, rx_prev_q;
  logic             rx_s, rx_fall;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  assign rx_s    = sync2_q;
  assign rx_fall = rx_prev_q & ~rx_s;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, whatever the statement order.
    if (!RST) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= SERIAL_RX;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Datapath and output registers: bit timer, shifter, holding register, pulses.
  always_ff @(posedge CLK) begin
    // NOTE: the holding register is reset explicitly because RX_DATA must
    // read 8'h00 after reset, not just be qualified by RX_VALID.
    if (!RST) begin
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state, bit sampling and holding-register update.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    // A transfer empties the holding register unless a load below refills it.
    if (valid_q && RX_READY) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_fall) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end

      START: begin
        if (cnt_q == '0) begin
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
            cnt_d     = FULL_LOAD;
          end else begin
            // Line went back high before mid-start-bit: treat as a glitch.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = FULL_LOAD;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      STOP: begin
        if (cnt_q == '0) begin
          // Return immediately after the stop sample so a following start
          // bit can be caught without waiting out the rest of the stop bit.
          state_d = IDLE;
          if (!rx_s) begin
            frame_err_d = 1'b1;
          end else if (!valid_q || RX_READY) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign RX_DATA   = data_q;
  assign RX_VALID  = valid_q;
  assign FRAME_ERR = frame_err_q;
  assign OVERRUN   = overrun_q;
  assign BUSY      = (state_q != IDLE);

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- 8N1 UART receiver. It deserialises SERIAL_RX into bytes and presents each byte on a valid/ready output port backed by a one-entry holding register.
- Sits inside top_np next to the existing transmit path, i.e. the receive end of the same serial link.
- Flags framing errors and overruns as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 104, CLK cycles per bit period (12 MHz / 115200). Legal range 4..65535; elaborating with a value outside this range is an error.
- CNT_W, 16, width of the bit-period counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  synchronous, active-low reset.
- SERIAL_RX  in  1  asynchronous serial input; idles high.
- RX_DATA  out  8  received byte; valid while RX_VALID=1.
- RX_VALID  out  1  holding register occupied.
- RX_READY  in  1  consumer accepts; a transfer occurs when RX_VALID and RX_READY are both 1 on a rising edge.
- FRAME_ERR  out  1  one-cycle pulse: stop bit sampled low.
- OVERRUN  out  1  one-cycle pulse: byte completed while the holding register was full and not being drained.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RST=0 at a rising edge):
  - state=IDLE.
  - Synchronizer flops = 1, counters = 0.
  - RX_DATA=8'h00, RX_VALID=0, FRAME_ERR=0, OVERRUN=0, BUSY=0.
  - Reset mid-frame abandons the frame with no error pulse.
- Input conditioning:
  - 2-flop synchronizer on SERIAL_RX gives rx_s, which lags the pin by 2 cycles.
  - A third flop holds rx_s from the previous cycle for falling-edge detection.
  - All timing below is relative to t0, the cycle in which the falling edge of rx_s is detected.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - On a falling edge of rx_s: go to START, load counter with CLKS_PER_BIT/2 - 1 (integer division).
  - A line held low continuously never retriggers; a new falling edge is required.
- START:
  - Count down; at 0, sample rx_s (sample cycle t0 + CLKS_PER_BIT/2).
  - If 0: go to DATA, bit index = 0, counter = CLKS_PER_BIT - 1.
  - If 1: glitch. Return to IDLE silently with no pulses.
- DATA:
  - At each counter expiry, sample rx_s into the shift register LSB first and reload the counter.
  - Bit i is sampled at t0 + CLKS_PER_BIT/2 + (i+1)*CLKS_PER_BIT.
  - After bit 7, go to STOP.
- STOP:
  - Sample at t0 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT.
  - The FSM returns to IDLE in the cycle after this sample. It does not wait out the second half of the stop bit, so back-to-back frames are accepted.
  - Stop sample = 0: FRAME_ERR pulses in the next cycle; the byte is discarded and the holding register is untouched.
  - Stop sample = 1, byte completes:
    - If RX_VALID=0, or RX_VALID=1 and RX_READY=1 in the same cycle: load RX_DATA; RX_VALID=1 on the next cycle. A simultaneous drain and load keeps RX_VALID high and shows the new byte.
    - If RX_VALID=1 and RX_READY=0: keep the old byte and drop the new one; OVERRUN pulses for 1 cycle.
- Output port:
  - RX_VALID clears the cycle after a transfer unless a load happens in that same cycle.
  - RX_DATA is stable while RX_VALID=1 and no transfer has occurred.
  - RX_READY is a don't-care while RX_VALID=0.
- Latency: RX_VALID rises one cycle after the stop-bit sample, i.e. t0 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1, which is 2 cycles later relative to the pin edge.
- FRAME_ERR and OVERRUN are never asserted for more than one consecutive cycle per frame, and never both in the same frame.

Test Plan (CLKS_PER_BIT=8 for all):
- Basic receive: reset, RX_READY=1, drive frame 0xA5 → RX_VALID high 1 cycle with RX_DATA=8'hA5 exactly t0+77 cycles; FRAME_ERR=0, OVERRUN=0.
- Back-to-back with backpressure: RX_READY=0, frames 0x3C then 0x81 with no idle gap → after 0x3C, RX_VALID=1 and RX_DATA=8'h3C; after 0x81, OVERRUN pulses once and RX_DATA stays 8'h3C. Raising RX_READY then clears RX_VALID on the next cycle.
- Simultaneous drain and load: hold 0x11, then assert RX_READY for exactly the stop-sample cycle of frame 0x22 → RX_VALID stays 1, RX_DATA becomes 8'h22, no OVERRUN.
- Framing error: frame 0x55 with the stop bit driven low → FRAME_ERR one pulse; RX_VALID stays 0. Line then returns high and frame 0x0F is sent → received correctly as 8'h0F.
- Start glitch: 2-cycle low pulse on SERIAL_RX → BUSY high for ≤6 cycles, then IDLE; no RX_VALID, FRAME_ERR or OVERRUN.
- Mid-frame reset: assert RST=0 for 1 cycle during bit 3 of frame 0xFF → all outputs at reset values the next cycle. A following full frame 0x96 is received as 8'h96.
